// File: rtl/code_loader_pkg.sv
// Shared i281 code-memory constants, loader state encoding and byte-position tags
// used by the loader FSM and its byte assembler.
package code_loader_pkg;

  localparam int CODE_ADDR_W = 6;
  localparam int CODE_WORD_W = 17;
  localparam int CODE_DEPTH  = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WR,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Which slot an accepted byte belongs to; POS_HDR only feeds the checksum.
  typedef enum logic [1:0] {
    POS_B0,
    POS_B1,
    POS_B2,
    POS_HDR
  } byte_pos_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects three little-endian bytes into a 17-bit instruction word and keeps the
// running XOR checksum of every byte it is handed.
module byte_word_assembler
  import code_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   byte_en,
  input  byte_pos_t              pos,
  input  logic [7:0]             data,
  output logic [CODE_WORD_W-1:0] word,
  output logic [7:0]             checksum
);

  logic [7:0]             lo_reg;
  logic [7:0]             mid_reg;
  logic [CODE_WORD_W-1:0] word_reg;
  logic [7:0]             sum_reg;

  // The word register only changes on the third byte, so it stays stable
  // while the next word's first two bytes are arriving.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo_reg   <= '0;
      mid_reg  <= '0;
      word_reg <= '0;
      sum_reg  <= '0;
    end else if (clear) begin
      lo_reg  <= '0;
      mid_reg <= '0;
      sum_reg <= '0;
    end else if (byte_en) begin
      sum_reg <= sum_reg ^ data;
      case (pos)
        POS_B0:  lo_reg   <= data;
        POS_B1:  mid_reg  <= data;
        POS_B2:  word_reg <= {data[0], mid_reg, lo_reg};
        default: ;
      endcase
    end
  end

  assign word     = word_reg;
  assign checksum = sum_reg;

endmodule

// File: rtl/code_loader.sv
// Host-to-code-memory loader: parses header, 3-byte words and a trailing XOR
// checksum, writes words sequentially and enables the CPU only after a clean load.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_W = CODE_ADDR_W,
  parameter int DEPTH  = CODE_DEPTH,
  parameter int WORD_W = CODE_WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   words_reg;
  logic [ADDR_W:0]   n_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        checksum;
  logic              xfer;
  logic              hdr_ok;
  logic              last_word;
  logic              session_start;
  logic              byte_en;
  byte_pos_t         pos;

  assign xfer          = in_valid && in_ready;
  assign hdr_ok        = (in_data != 8'd0) && (32'(in_data) <= 32'(DEPTH));
  assign last_word     = (words_reg + (ADDR_W+1)'(1)) == n_reg;
  assign session_start = start &&
                         (state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERROR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    mem_we     = 1'b0;
    byte_en    = 1'b0;
    pos        = POS_HDR;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_HDR;
      ST_HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        byte_en  = xfer;
        if (xfer) state_next = hdr_ok ? ST_B0 : ST_ERROR;
      end
      ST_B0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        byte_en  = xfer;
        pos      = POS_B0;
        if (xfer) state_next = ST_B1;
      end
      ST_B1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        byte_en  = xfer;
        pos      = POS_B1;
        if (xfer) state_next = ST_B2;
      end
      ST_B2: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        byte_en  = xfer;
        pos      = POS_B2;
        if (xfer) state_next = ST_WR;
      end
      ST_WR: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        state_next = last_word ? ST_CHK : ST_B0;
      end
      ST_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = (in_data == checksum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  if (start) state_next = ST_HDR;
      ST_ERROR: begin
        error = 1'b1;
        if (start) state_next = ST_HDR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write address is captured with the third byte so it holds between writes,
  // while the word counter advances after each write strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_reg <= '0;
      n_reg     <= '0;
      addr_reg  <= '0;
    end else if (session_start) begin
      words_reg <= '0;
      addr_reg  <= '0;
    end else begin
      if (state_reg == ST_HDR && xfer && hdr_ok) n_reg <= in_data[ADDR_W:0];
      if (state_reg == ST_B2 && xfer)            addr_reg <= words_reg[ADDR_W-1:0];
      if (state_reg == ST_WR)                    words_reg <= words_reg + (ADDR_W+1)'(1);
    end
  end

  byte_word_assembler u_asm (
    .clock    (clock),
    .reset    (reset),
    .clear    (session_start),
    .byte_en  (byte_en),
    .pos      (pos),
    .data     (in_data),
    .word     (mem_wdata),
    .checksum (checksum)
  );

  // A restart from DONE withdraws run in the very cycle start is seen.
  assign run          = (state_reg == ST_DONE) && !start;
  assign mem_addr     = addr_reg;
  assign words_loaded = words_reg;

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: session table plus hand sequences for reset
// mid-load, a full 64-word load with stalls, and restart behaviour.
module tb_code_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [16:0] mem_wdata;
  logic        run;
  logic        busy;
  logic        error;
  logic [6:0]  words_loaded;

  int passed = 0;
  int total  = 0;

  logic [5:0]  wa_q[$];
  logic [16:0] wd_q[$];
  logic        prev_we = 1'b0;

  typedef struct {
    logic [7:0]  n;
    int          nbytes;
    logic [47:0] b;
    logic [7:0]  cs;
    int          exp_words;
    logic [16:0] w0;
    logic [16:0] w1;
    logic        exp_run;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  code_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .run          (run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      $display("write addr=%0d data=%05h", mem_addr, mem_wdata);
      check("ready_low_on_wr", 32'(in_ready), 32'd0);
      check("we_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we <= mem_we;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit randv);
    int  budget = 0;
    bit  done   = 0;
    in_data = b;
    while (!done) begin
      in_valid = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (in_valid && in_ready) done = 1;
      @(posedge clock); #1;
      budget++;
      if (!done && budget > 200) begin
        check("handshake_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_session(input int idx, input vec_t v);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(v.n, 1'b0);
    if (v.nbytes > 0) begin
      for (int k = 0; k < v.nbytes; k++) send_byte(v.b[8*k +: 8], 1'b0);
      send_byte(v.cs, 1'b0);
    end
    @(negedge clock);
    $display("session %0d: n=%0h run=%0b error=%0b busy=%0b words=%0d writes=%0d",
             idx, v.n, run, error, busy, words_loaded, wa_q.size());
    check("sess_run", 32'(run), 32'(v.exp_run));
    check("sess_error", 32'(error), 32'(v.exp_err));
    check("sess_busy", 32'(busy), 32'd0);
    check("sess_words", 32'(words_loaded), 32'(v.exp_words));
    check("sess_we_count", 32'(wa_q.size()), 32'(v.exp_words));
    for (int i = 0; i < v.exp_words && i < wa_q.size(); i++) begin
      check("sess_addr", 32'(wa_q[i]), 32'(i));
      check("sess_data", 32'(wd_q[i]), 32'(i == 0 ? v.w0 : v.w1));
    end
    if (v.exp_words > 0) begin
      check("hold_addr", 32'(mem_addr), 32'(v.exp_words - 1));
      check("hold_data", 32'(mem_wdata), 32'(v.exp_words == 1 ? v.w0 : v.w1));
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cs;
    logic [7:0]  b0, b1, b2;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    vecs[0] = '{n:8'h02, nbytes:6, b:48'h000F0F01A5C3, cs:8'h65, exp_words:2,
                w0:17'h1A5C3, w1:17'h00F0F, exp_run:1'b1, exp_err:1'b0};
    vecs[1] = '{n:8'h02, nbytes:6, b:48'h000F0F01A5C3, cs:8'h64, exp_words:2,
                w0:17'h1A5C3, w1:17'h00F0F, exp_run:1'b0, exp_err:1'b1};
    vecs[2] = '{n:8'h00, nbytes:0, b:48'h0, cs:8'h00, exp_words:0,
                w0:17'h0, w1:17'h0, exp_run:1'b0, exp_err:1'b1};
    vecs[3] = '{n:8'h41, nbytes:0, b:48'h0, cs:8'h00, exp_words:0,
                w0:17'h0, w1:17'h0, exp_run:1'b0, exp_err:1'b1};
    vecs[4] = '{n:8'h01, nbytes:3, b:48'h000000FFFFFF, cs:8'hFE, exp_words:1,
                w0:17'h1FFFF, w1:17'h0, exp_run:1'b1, exp_err:1'b0};
    vecs[5] = '{n:8'h01, nbytes:3, b:48'h000000030000, cs:8'h02, exp_words:1,
                w0:17'h10000, w1:17'h0, exp_run:1'b1, exp_err:1'b0};

    repeat (2) @(posedge clock);
    #1;
    $display("reset values: run=%0b busy=%0b error=%0b in_ready=%0b", run, busy, error, in_ready);
    check("rst_run", 32'(run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) run_session(i, vecs[i]);

    // Reset while waiting for the second byte of a word.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    check("midb1_ready", 32'(in_ready), 32'd1);
    check("midb1_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    $display("reset mid-B1: busy=%0b in_ready=%0b run=%0b", busy, in_ready, run);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_run", 32'(run), 32'd0);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_mem_we", 32'(mem_we), 32'd0);
    check("mrst_words", 32'(words_loaded), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("mrst_idle_ready", 32'(in_ready), 32'd0);
    check("mrst_idle_run", 32'(run), 32'd0);

    // Full-depth load with a randomly stalling host.
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    cs = 8'd64;
    send_byte(8'd64, 1'b1);
    for (int i = 0; i < 64; i++) begin
      b0 = 8'(i) ^ 8'h5A;
      b1 = 8'(i * 3);
      b2 = 8'(i);
      cs = cs ^ b0 ^ b1 ^ b2;
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      send_byte(b2, 1'b1);
    end
    send_byte(cs, 1'b1);
    @(negedge clock);
    $display("full load: run=%0b words=%0d writes=%0d", run, words_loaded, wa_q.size());
    check("full_run", 32'(run), 32'd1);
    check("full_words", 32'(words_loaded), 32'd64);
    check("full_we_count", 32'(wa_q.size()), 32'd64);
    for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
      b0 = 8'(i) ^ 8'h5A;
      b1 = 8'(i * 3);
      check("full_addr", 32'(wa_q[i]), 32'(i));
      check("full_data", 32'(wd_q[i]), {15'd0, 1'(i), b1, b0});
    end
    @(posedge clock); #1;

    // start during B2 is ignored; start from DONE restarts at address 0.
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hA5, 1'b0);
    pulse_start();
    check("b2_start_busy", 32'(busy), 32'd1);
    check("b2_start_ready", 32'(in_ready), 32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h65, 1'b0);
    @(negedge clock);
    $display("ignored start: run=%0b words=%0d writes=%0d", run, words_loaded, wa_q.size());
    check("ign_run", 32'(run), 32'd1);
    check("ign_words", 32'(words_loaded), 32'd2);
    check("ign_we_count", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("ign_addr1", 32'(wa_q[1]), 32'd1);
      check("ign_data0", 32'(wd_q[0]), 32'h1A5C3);
    end
    @(posedge clock); #1;
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    #1;
    check("restart_run_drop", 32'(run), 32'd0);
    @(posedge clock); #1;
    start = 1'b0;
    $display("restart: run=%0b busy=%0b words=%0d addr=%0d", run, busy, words_loaded, mem_addr);
    check("restart_run", 32'(run), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_words", 32'(words_loaded), 32'd0);
    check("restart_addr", 32'(mem_addr), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h27, 1'b0);
    @(negedge clock);
    $display("restart session: run=%0b words=%0d writes=%0d", run, words_loaded, wa_q.size());
    check("rs_run", 32'(run), 32'd1);
    check("rs_words", 32'(words_loaded), 32'd1);
    check("rs_we_count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("rs_addr", 32'(wa_q[0]), 32'd0);
      check("rs_data", 32'(wd_q[0]), 32'h01234);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
- Writer-side front end for the i281 code memory.
- Accepts a byte stream from a host link over a valid/ready handshake and assembles 17-bit instruction words.
- Writes the words into code memory at sequential addresses, verifies a trailing XOR checksum, and releases `run` to the CPU only after a clean load.
- Sits between the host interface and the codemem write port. It holds the CPU halted, with `run` low, for the whole load.

Parameters:
- ADDR_W, 6, code memory address width (matches the 6-bit PC).
- DEPTH, 64, maximum number of words; must equal 2**ADDR_W.
- WORD_W, 17, instruction word width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts the byte this cycle.
- mem_we  output  1  code memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  code memory write address.
- mem_wdata  output  WORD_W  code memory write data.
- run  output  1  CPU run enable; high only in DONE.
- busy  output  1  high from accepting `start` until DONE or ERROR.
- error  output  1  sticky error flag; high in ERROR.
- words_loaded  output  ADDR_W+1  count of words written this session.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0; `mem_addr`, `mem_wdata`, `words_loaded` = 0.
  - Internal checksum and word count = 0.
- Handshake:
  - A byte transfers on a rising edge where `in_valid` and `in_ready` are both 1.
  - `in_ready` is a function of state only. It is 1 in HDR, B0, B1, B2 and CHK, and 0 elsewhere.
- Stream format:
  - Header byte N (word count), then 3 bytes per word, little-endian: B0 = bits[7:0], B1 = bits[15:8], B2 bit0 = bit16.
  - B2 bits[7:1] are ignored for data but included in the checksum.
  - Then one checksum byte. The checksum is the XOR of N and every data byte.
- States:
  - IDLE: on `start` → HDR. Clear `words_loaded`, `mem_addr`, checksum, `error`; set `busy`.
  - HDR: on transfer, if N == 0 or N > DEPTH → ERROR. Otherwise latch N, checksum ^= N, → B0.
  - B0, B1, B2: each transfer latches its byte into the word shift register and XORs it into the checksum. B0→B1→B2; after B2 → WR.
  - WR (exactly one cycle): `mem_we`=1, `mem_wdata` = assembled word, `mem_addr` = current address. Next cycle: address+1, `words_loaded`+1. If `words_loaded`+1 == N → CHK, else → B0.
  - CHK: on transfer, compare the byte with the checksum. Equal → DONE, otherwise → ERROR.
  - DONE: `run`=1, `busy`=0. Holds until `start`, which → HDR and drops `run` in the same cycle. Memory contents stay valid.
  - ERROR: `error`=1, `run`=0, `busy`=0. Holds until `start` (→ HDR, clears `error`).
- Latency:
  - Per word: 3 accepted bytes + 1 WR cycle, so at least 4 cycles per word.
  - The WR cycle inserts one bubble with `in_ready`=0.
- Boundary conditions:
  - `start` while in HDR/B0/B1/B2/WR/CHK is ignored; the session continues.
  - N = DEPTH writes addresses 0..DEPTH-1. The address counter never wraps inside a session.
  - `in_valid` low stalls indefinitely in any input state. No timeout.
  - `mem_we` is never high in more than one consecutive cycle.
  - `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.
  - Reset mid-load returns to IDLE immediately. Already-written words remain in code memory but `run` stays 0.
  - `run` is never 1 unless the last session passed its checksum.

Decomposition:
- Shared package:
  - state encoding (IDLE, HDR, B0, B1, B2, WR, CHK, DONE, ERROR);
  - the i281 constants CODE_ADDR_W=6, CODE_WORD_W=17, CODE_DEPTH=64.
- One sub-module, `byte_word_assembler`: the 3-byte shift/latch into the 17-bit word plus the running XOR checksum, with a clear input and a byte-enable input.
- The FSM and address counter stay in `code_loader`.

Test Plan:
- Reset asserted mid-B1 → next cycle state IDLE; `run`/`busy`/`error`/`mem_we`=0; `words_loaded`=0.
- `start`, then N=2, words 0x1A5C3 (bytes C3,A5,01) and 0x00F0F (0F,0F,00), checksum 0x02^C3^A5^01^0F^0F^00=0x65 → writes addr0=0x1A5C3, addr1=0x00F0F; `run`=1; `words_loaded`=2.
- Same stream with checksum 0x64 → `error`=1, `run`=0; both words were still written.
- Header 0x00, then header 0x41 (65), each in a fresh session → ERROR after the header; no `mem_we` pulses.
- `in_valid` toggled randomly with N=64 → exactly 64 single-cycle `mem_we` pulses, addresses 0..63 in order, `in_ready` low on every WR cycle; ends in DONE.
- `start` pulsed during B2, then again after DONE → first pulse ignored; second drops `run` in the same cycle and a new session starts at addr0.
